// File: rtl/riscv_pkg.sv
// Shared RV32 core constants: data width, instruction length, NOP encoding
// and the default reset PC.
package riscv_pkg;
    localparam int          XLEN         = 32;
    localparam int          ILEN         = 4;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
endpackage

// File: rtl/fetch_perf_ctr.sv
// Fetch performance counters: instructions handed to decode and stall cycles.
// Both counters are free-running and wrap at 2^32.
module fetch_perf_ctr
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic            id_ready,
    input  logic            redirect_valid,
    output logic [XLEN-1:0] fetch_cnt,
    output logic [XLEN-1:0] stall_cnt
);

    logic fetch_hit;
    logic stall_hit;

    // A redirect squashes the word decode sees this cycle, so it is not counted.
    assign fetch_hit = if_valid && id_ready && !redirect_valid;
    assign stall_hit = if_valid && !id_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (fetch_hit) fetch_cnt <= fetch_cnt + 1'b1;
            if (stall_hit) stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage: PC register, next-PC mux and IF/ID register.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int unsigned MEM_DEPTH = 1024,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rd,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            if_fault,
    output logic [XLEN-1:0] perf_fetch_cnt,
    output logic [XLEN-1:0] perf_stall_cnt
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] redirect_target;
    logic            accept;
    logic            in_range;

    assign imem_addr       = pc_q;
    assign redirect_target = redirect_pc & ~32'(ILEN - 1);
    assign accept          = !if_valid || id_ready;
    assign in_range        = {2'b00, pc_q[XLEN-1:2]} < MEM_DEPTH;

    // Redirect beats capture; a faulting fetch still advances the PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
            if_pc    <= '0;
            if_fault <= 1'b0;
        end else if (redirect_valid) begin
            pc_q     <= redirect_target;
            if_valid <= 1'b0;
        end else if (accept) begin
            if_instr <= in_range ? imem_rd : NOP_INSTR;
            if_pc    <= pc_q;
            if_fault <= !in_range;
            if_valid <= 1'b1;
            pc_q     <= pc_q + 32'(ILEN);
        end
    end

`ifdef FETCH_PERF_EN
    fetch_perf_ctr u_perf (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (if_valid),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .fetch_cnt      (perf_fetch_cnt),
        .stall_cnt      (perf_stall_cnt)
    );
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random redirect/stall
// traffic, all checked against a transaction-level reference model.
module tb_fetch_stage;
    localparam int MEM_WORDS = 1024;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr, imem_rd;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        if_valid, if_fault;
    logic [31:0] if_instr, if_pc, perf_fetch_cnt, perf_stall_cnt;

    logic [31:0] mem [0:MEM_WORDS-1];

    int checks = 0;
    int passed = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr, m_if_pc;
    logic        m_fault;
    logic [31:0] m_fetch, m_stall;

    always #5 clk = ~clk;

    // Out-of-range addresses alias into the array on purpose: the DUT must NOP them.
    assign imem_rd = mem[imem_addr[11:2]];

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_fault       (if_fault),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_valid = 1'b0; m_instr = NOP; m_if_pc = 32'h0;
        m_fault = 1'b0; m_fetch = 32'h0; m_stall = 32'h0;
    endtask

    // One rising edge of the fetch stage as seen by decode.
    task automatic model_step(input logic rv, input logic [31:0] rpc, input logic rdy);
`ifdef FETCH_PERF_EN
        if (m_valid && rdy && !rv) m_fetch = m_fetch + 1;
        if (m_valid && !rdy) m_stall = m_stall + 1;
`endif
        if (rv) begin
            m_pc    = (rpc / 4) * 4;
            m_valid = 1'b0;
        end else if (!m_valid || rdy) begin
            m_fault = !(m_pc < MEM_WORDS * 4);
            m_instr = m_fault ? NOP : mem[m_pc / 4];
            m_if_pc = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 4;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"},  imem_addr, m_pc);
        chk({tag, ".valid"}, 32'(if_valid), 32'(m_valid));
        chk({tag, ".instr"}, if_instr, m_instr);
        chk({tag, ".pc"},    if_pc, m_if_pc);
        chk({tag, ".fault"}, 32'(if_fault), 32'(m_fault));
        chk({tag, ".pfetch"}, perf_fetch_cnt, m_fetch);
        chk({tag, ".pstall"}, perf_stall_cnt, m_stall);
    endtask

    // Inputs change right after a falling edge; outputs are sampled at the next one.
    task automatic cycle(input string tag, input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        @(posedge clk);
        model_step(rv, rpc, rdy);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2009_0003;
        mem[2] = 32'h0109_5020;
        model_reset();

        // Reset state, with the clock running
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b1;

        // Straight-line fetch, one per cycle
        cycle("seq0", 1'b0, 32'h0, 1'b1);
        chk("seq0.instr_lit", if_instr, 32'h2008_0005);
        cycle("seq1", 1'b0, 32'h0, 1'b1);
        chk("seq1.pc_lit", if_pc, 32'h4);

        // Stall three cycles holding 4/20090003
        for (int i = 0; i < 3; i++) cycle("stall", 1'b0, 32'h0, 1'b0);
        chk("stall.instr_lit", if_instr, 32'h2009_0003);
        chk("stall.addr_lit", imem_addr, 32'h8);

        // Redirect while stalled; low bits dropped
        cycle("redir", 1'b1, 32'h6, 1'b0);
        chk("redir.addr_lit", imem_addr, 32'h4);
        cycle("redir_cap", 1'b0, 32'h0, 1'b1);

        // First out-of-range word
        cycle("oor_redir", 1'b1, 32'h1000, 1'b1);
        cycle("oor0", 1'b0, 32'h0, 1'b1);
        chk("oor0.fault_lit", 32'(if_fault), 32'h1);
        cycle("oor1", 1'b0, 32'h0, 1'b1);
        chk("oor1.pc_lit", if_pc, 32'h1004);

        // Top of address space wraps to 0
        cycle("wrap_redir", 1'b1, 32'hFFFF_FFFC, 1'b1);
        cycle("wrap", 1'b0, 32'h0, 1'b1);
        chk("wrap.addr_lit", imem_addr, 32'h0);

        // Back-to-back redirects, the last one wins
        cycle("b2b0", 1'b1, 32'h40, 1'b1);
        cycle("b2b1", 1'b1, 32'h8, 1'b1);
        cycle("b2b_cap", 1'b0, 32'h0, 1'b1);
        chk("b2b.instr_lit", if_instr, 32'h0109_5020);

        // Asynchronous reset between edges
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
        check_all("async_rel");
        cycle("restart", 1'b0, 32'h0, 1'b1);
        chk("restart.pc_lit", if_pc, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic        rv, rdy;
            logic [31:0] rpc;
            rv  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0: rpc = $urandom_range(0, 64);
                1: rpc = 32'h0FF0 + $urandom_range(0, 31);
                2: rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                default: rpc = $urandom;
            endcase
            if (i % 7 == 3) mem[$urandom_range(0, MEM_WORDS - 1)] = $urandom;
            cycle("rand", rv, rpc, rdy);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
